// File: rtl/mem_port_pkg.sv
// Shared definitions for mem_port: instruction field positions, FSM state
// encodings and the default bus timeout.
package mem_port_pkg;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;

    localparam int MEMP_TIMEOUT = 255;

    typedef enum logic [1:0] {
        MEMP_IDLE = 2'd0,
        MEMP_WAIT = 2'd1,
        MEMP_DONE = 2'd2
    } memp_state_e;

endpackage

// File: rtl/mem_port.sv
// Memory access port: turns control strobes into a req/ack bus transaction and
// stalls control until it completes. Define MEM_TIMEOUT_EN to add a bus timeout.
module mem_port
    import mem_port_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = MEMP_TIMEOUT
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              iord,
    input  logic              ir_we,
    input  logic              mdr_we,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] ir,
    output logic [5:0]        op,
    output logic [5:0]        func,
    output logic [DATA_W-1:0] mdr,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_err
);

    memp_state_e       state_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wdata_q;
    logic              ir_we_q;
    logic              mdr_we_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] mdr_q;

    logic              req;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] bus_addr_d;
    logic              timeout_hit;
    logic              unused_ok;

    assign req        = mem_read | mem_write;
    assign sel_addr   = iord ? alu_out : pc;
    assign bus_addr_d = {sel_addr[ADDR_W-1:2], 2'b00};
    assign unused_ok  = ^sel_addr[1:0];

    // Gated by nrst so control never sees a stall while the port is held in reset.
    assign stall = nrst & req & (state_q != MEMP_DONE);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt_q;
    logic             bus_err_q;

    // Counter sits at zero outside WAIT, so it is cleared on every WAIT entry.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else if (state_q != MEMP_WAIT) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == MEMP_WAIT) && !bus_ack
                         && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bus_err_q <= 1'b0;
        end else if (timeout_hit) begin
            bus_err_q <= 1'b1;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= MEMP_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            ir_we_q     <= 1'b0;
            mdr_we_q    <= 1'b0;
            ir_q        <= '0;
            mdr_q       <= '0;
        end else begin
            case (state_q)
                MEMP_IDLE: begin
                    if (req) begin
                        state_q     <= MEMP_WAIT;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mem_write;
                        bus_addr_q  <= bus_addr_d;
                        bus_wdata_q <= wdata;
                        ir_we_q     <= ir_we;
                        mdr_we_q    <= mdr_we;
                    end
                end
                MEMP_WAIT: begin
                    if (bus_ack) begin
                        state_q   <= MEMP_DONE;
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        // A latched write (including read+write conflicts) never loads.
                        if (!bus_we_q) begin
                            if (ir_we_q)  ir_q  <= bus_rdata;
                            if (mdr_we_q) mdr_q <= bus_rdata;
                        end
                    end else if (timeout_hit) begin
                        state_q   <= MEMP_DONE;
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                    end
                end
                MEMP_DONE: state_q <= MEMP_IDLE;
                default:   state_q <= MEMP_IDLE;
            endcase
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign ir        = ir_q;
    assign mdr       = mdr_q;
    assign op        = ir_q[OP_MSB:OP_LSB];
    assign func      = ir_q[FUNC_MSB:FUNC_LSB];

endmodule

// File: tb/tb_mem_port.sv
// Self-checking bench for mem_port: directed accesses plus randomized traffic
// against a transaction-level model of ir, mdr and bus_err.
module tb_mem_port;

`ifdef MEM_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
    localparam int MAX_D      = 3;
`else
    localparam int TB_TIMEOUT = 255;
    localparam int MAX_D      = 6;
`endif

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0, iord = 1'b0;
    logic        ir_we = 1'b0, mdr_we = 1'b0;
    logic [31:0] pc = '0, alu_out = '0, wdata = '0;
    logic        stall;
    logic [31:0] ir, mdr;
    logic [5:0]  op, func;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_err;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [31:0] ir_m  = '0;
    logic [31:0] mdr_m = '0;
    logic        err_m = 1'b0;

    mem_port #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .iord     (iord),
        .ir_we    (ir_we),
        .mdr_we   (mdr_we),
        .pc       (pc),
        .alu_out  (alu_out),
        .wdata    (wdata),
        .stall    (stall),
        .ir       (ir),
        .op       (op),
        .func     (func),
        .mdr      (mdr),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ack  (bus_ack),
        .bus_rdata(bus_rdata),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_ir"},   ir,        ir_m);
        check({tag, "_mdr"},  mdr,       mdr_m);
        check({tag, "_op"},   32'(op),   32'(ir_m[31:26]));
        check({tag, "_func"}, 32'(func), 32'(ir_m[5:0]));
        check({tag, "_err"},  32'(bus_err), 32'(err_m));
    endtask

    // Control idle cycles: no request, stray routing strobes and stray acks.
    task automatic idle(input int n, input logic force_ack);
        for (int i = 0; i < n; i++) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_we     = 1'($urandom_range(0, 1));
            mdr_we    = 1'($urandom_range(0, 1));
            iord      = 1'($urandom_range(0, 1));
            pc        = $urandom;
            alu_out   = $urandom;
            bus_ack   = force_ack | 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
            #1 check("idle_stall", 32'(stall), 32'd0);
            step();
            check("idle_req", 32'(bus_req), 32'd0);
            check_regs("idle");
        end
        bus_ack = 1'b0;
    endtask

    // One access from the IDLE cycle through DONE; d = wait cycles before the
    // ack (ack arrives in cycle 1+d), d < 0 means the ack never comes.
    task automatic do_access(input logic rd, input logic wr, input logic sel,
                             input logic irw, input logic mdrw,
                             input logic [31:0] pcv, input logic [31:0] aluv,
                             input logic [31:0] wd, input logic [31:0] rdat,
                             input int d);
        logic [31:0] exp_addr;
        int          n_wait;
        exp_addr  = (sel ? aluv : pcv) & 32'hFFFF_FFFC;
        mem_read  = rd;
        mem_write = wr;
        iord      = sel;
        ir_we     = irw;
        mdr_we    = mdrw;
        pc        = pcv;
        alu_out   = aluv;
        wdata     = wd;
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
        #1 check("c0_stall", 32'(stall), 32'd1);
        step();
        pc      = $urandom;
        alu_out = $urandom;
        wdata   = $urandom;
        check("c1_req",   32'(bus_req), 32'd1);
        check("c1_addr",  bus_addr,     exp_addr);
        check("c1_we",    32'(bus_we),  32'(wr));
        check("c1_wdata", bus_wdata,    wd);
        n_wait = (d < 0) ? TB_TIMEOUT : d;
        for (int i = 0; i < n_wait; i++) begin
            check("wait_stall", 32'(stall),   32'd1);
            check("wait_req",   32'(bus_req), 32'd1);
            step();
        end
        if (d >= 0) begin
            bus_ack   = 1'b1;
            bus_rdata = rdat;
            check("ack_stall", 32'(stall), 32'd1);
            step();
            if (rd && !wr) begin
                if (irw)  ir_m  = rdat;
                if (mdrw) mdr_m = rdat;
            end
        end else begin
            err_m = 1'b1;
        end
        bus_ack   = 1'b1 & 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        check("done_stall", 32'(stall),   32'd0);
        check("done_req",   32'(bus_req), 32'd0);
        check("done_we",    32'(bus_we),  32'd0);
        check_regs("done");
        step();
        bus_ack = 1'b0;
        check_regs("post");
    endtask

    initial begin
        mem_read = 1'b1;
        #12;
        check("rst_stall", 32'(stall),   32'd0);
        check("rst_req",   32'(bus_req), 32'd0);
        check("rst_we",    32'(bus_we),  32'd0);
        check("rst_addr",  bus_addr,     32'd0);
        check("rst_wdata", bus_wdata,    32'd0);
        check_regs("rst");
        mem_read = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        step();

        // Instruction fetch, ack in cycle 1
        do_access(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0004, $urandom, $urandom,
                  32'h0123_4820, 0);
        check("fetch_func", 32'(func), 32'h20);

        // Load with wait states, unaligned address
        do_access(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, $urandom, 32'h0000_0103, $urandom,
                  32'hDEAD_BEEF, (MAX_D >= 4) ? 4 : MAX_D);
        check("load_mdr", mdr, 32'hDEAD_BEEF);

        // Store with both routing strobes set: nothing may be loaded
        do_access(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, $urandom, 32'h0000_0020, 32'hCAFE_0001,
                  $urandom, 1);

        // Read/write conflict: write wins
        do_access(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_1008, $urandom, $urandom,
                  $urandom, 2);

        // Stray acks while idle
        idle(3, 1'b1);

        // Back-to-back reads, request held across DONE
        do_access(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom, 0);
        do_access(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom, 1);

        // Reset in WAIT with an ack arriving during reset
        mem_read = 1'b1; mem_write = 1'b0; iord = 1'b0; ir_we = 1'b1; mdr_we = 1'b1;
        pc = 32'h0000_0040;
        step();
        check("rw_req_before", 32'(bus_req), 32'd1);
        #2;
        nrst      = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'h5555_AAAA;
        #1;
        ir_m = '0; mdr_m = '0; err_m = 1'b0;
        check("rw_req",   32'(bus_req), 32'd0);
        check("rw_stall", 32'(stall),   32'd0);
        check_regs("rw");
        @(negedge clk);
        @(negedge clk);
        nrst     = 1'b1;
        bus_ack  = 1'b0;
        mem_read = 1'b0;
        step();
        check("rw_req_after", 32'(bus_req), 32'd0);
        check_regs("rw_after");
        do_access(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0080, $urandom, $urandom,
                  32'h8C22_0004, 0);

`ifdef MEM_TIMEOUT_EN
        // Ack in the last allowed WAIT cycle beats the timeout
        do_access(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, $urandom, $urandom, $urandom,
                  $urandom, TB_TIMEOUT - 1);
        // No ack at all: bus_err set, ir/mdr untouched
        do_access(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, $urandom, $urandom, $urandom,
                  $urandom, -1);
        do_access(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, $urandom, $urandom, $urandom,
                  $urandom, 0);
`endif

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            int kind;
            idle($urandom_range(0, 2), 1'b0);
            kind = $urandom_range(0, 3);
            do_access((kind != 2), (kind >= 2), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom, $urandom, $urandom, $urandom,
                      $urandom_range(0, MAX_D));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port.md
# mem_port

Memory access port between the multi-cycle control FSM and the unified instruction/data memory bus. It turns the control strobes (memory read, memory write, PC-vs-ALU address select, IR write, MDR write) into a registered request/acknowledge bus transaction. It captures returned data into the instruction register or the memory data register, and asserts a stall so the control FSM holds its current state until the access completes. It drives the opcode and function fields consumed by the control FSM.

## Interface
Parameters:
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width
- TIMEOUT, 255, maximum wait cycles for bus_ack; used only with MEM_TIMEOUT_EN

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  reset, asynchronous, active-low
- mem_read  in  1  read strobe from control
- mem_write  in  1  write strobe from control
- iord  in  1  address select: 0 = pc, 1 = alu_out
- ir_we  in  1  route read data to the IR
- mdr_we  in  1  route read data to the MDR
- pc  in  ADDR_W  program counter
- alu_out  in  ADDR_W  registered ALU result
- wdata  in  DATA_W  store data (register B)
- stall  out  1  access in progress; control holds state while high
- ir  out  DATA_W  instruction register
- op  out  6  ir[31:26]
- func  out  6  ir[5:0]
- mdr  out  DATA_W  memory data register
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  word-aligned address
- bus_wdata  out  DATA_W  write data
- bus_ack  in  1  one-cycle completion pulse
- bus_rdata  in  DATA_W  read data, valid with bus_ack
- bus_err  out  1  sticky timeout flag

## Operation
- The FSM has three states: IDLE, WAIT, DONE.
- IDLE to WAIT on req = mem_read | mem_write. On this transition the block:
  - latches bus_addr = {sel[ADDR_W-1:2], 2'b00}, where sel = iord ? alu_out : pc;
  - latches bus_we = mem_write and bus_wdata = wdata;
  - latches the ir_we and mdr_we routing;
  - sets bus_req = 1.
- If mem_read and mem_write are both high, the write wins and the read is dropped.
- WAIT to DONE on bus_ack. On this transition the block:
  - clears bus_req and bus_we;
  - on a read, loads bus_rdata into ir if the latched ir_we is set, and into mdr if the latched mdr_we is set (both may be set);
  - on a write, leaves ir and mdr unchanged.
- DONE to IDLE unconditionally. Request inputs are ignored in DONE; they still belong to the control state now being released.
- stall = req & (state != DONE), combinational. stall is forced to 0 while nrst is low.
- ir_we or mdr_we without mem_read has no effect. ir and mdr hold their value unless loaded.
- bus_ack in IDLE or DONE is ignored.
- The control FSM's state register advances only when stall is low.

## Timing
- Reset values: state IDLE; bus_req, bus_we, bus_err = 0; bus_addr, bus_wdata, ir, mdr = 0; op and func = 0.
- Cycle 0: request seen, stall = 1.
- Cycle 1: bus_req = 1 (earliest cycle a bus_ack is accepted).
- Cycle k: bus_ack arrives.
- Cycle k+1: DONE, ir/mdr updated, stall = 0, control advances at the end of this cycle.
- Minimum access latency is 3 cycles (ack in cycle 1).
- A back-to-back request is accepted in the cycle after DONE.
- Reset mid-access: bus_req drops immediately (asynchronous), and a partial read is not captured.

## Configuration
- MEM_TIMEOUT_EN defined:
  - an 8+ bit counter runs in WAIT and clears on entry;
  - after TIMEOUT cycles without bus_ack, bus_err is set (sticky until reset), bus_req is cleared, and the FSM goes to DONE with ir and mdr unchanged;
  - a bus_ack in the same cycle as the timeout takes priority and does not set bus_err.
- MEM_TIMEOUT_EN undefined: WAIT lasts until bus_ack with no limit, bus_err is tied to 0, and no counter is built.

## Structure
- The shared defines file holds the opcode field positions (OP_MSB=31, OP_LSB=26, FUNC_MSB=5, FUNC_LSB=0), the state encodings (MEMP_IDLE=2'd0, MEMP_WAIT=2'd1, MEMP_DONE=2'd2) and the default TIMEOUT.
- The block is one module with no sub-module. The timeout counter is a guarded always block inside it.

## Test plan
- Instruction fetch: mem_read=1, iord=0, ir_we=1, pc=0x0000_0004; bus_ack in cycle 1 with rdata=0x0123_4820 -> bus_addr=0x4; in cycle 2 ir=0x0123_4820, op=0, func=0x20, stall=0.
- Load with wait states: iord=1, mdr_we=1, alu_out=0x0000_0103; bus_ack in cycle 5, rdata=0xDEAD_BEEF -> bus_addr=0x100, stall high in cycles 0-5, mdr=0xDEAD_BEEF in cycle 6, ir unchanged.
- Store: mem_write=1, iord=1, alu_out=0x20, wdata=0xCAFE_0001 -> bus_we=1, bus_wdata=0xCAFE_0001, bus_addr=0x20; after ack, ir and mdr unchanged.
- Conflict and stray ack: mem_read=mem_write=1 -> bus_we=1; bus_ack pulsed while IDLE -> no state change.
- Reset in WAIT: nrst low for 1 cycle -> bus_req=0 immediately, ir and mdr =0, next request starts cleanly.
- MEM_TIMEOUT_EN with TIMEOUT=4 and no ack -> bus_err=1 after 4 WAIT cycles, stall drops, bus_err still 1 after later successful accesses.
